// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM load arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    LOAD = 2'd2
  } arb_state_t;

  localparam logic [3:0] SEL_HI      = 4'b1100;
  localparam logic [3:0] SEL_LO      = 4'b0011;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Map a loader 32-bit word offset onto the SDRAM byte address space.
  // The sum is 26 bits wide so any overflow simply wraps.
  function automatic logic [25:0] ld_to_ram_adr(input logic [25:0] base,
                                                input logic [21:0] word_ofs);
    return base + {2'b00, word_ofs, 2'b00};
  endfunction

endpackage

// File: rtl/ld_buffer.sv
// One-entry capture register for loader writes. Holds the pending 16-bit
// word, drives ioctl_wait back-pressure and flags writes that arrive while
// a word is still pending.
module ld_buffer
  import sdram_arb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ld_en,
  input  logic        i_ld_wr,
  input  logic [24:0] i_ld_addr,
  input  logic [15:0] i_ld_dat,
  input  logic        i_release,
  output logic        o_ld_wait,
  output logic        o_overrun,
  output logic [22:0] o_addr,
  output logic [15:0] o_dat
);

  logic        r_full;
  logic [22:0] r_addr;
  logic [15:0] r_dat;
  logic        w_wr;
  logic        w_capture;
  logic        w_unused_addr;

  // Only byte-address bits [23:1] matter: bit 0 is implied by 16-bit words
  // and bit 24 is beyond the loader window.
  assign w_unused_addr = i_ld_addr[24] ^ i_ld_addr[0];

  assign w_wr      = i_ld_wr & i_ld_en;
  assign w_capture = w_wr & ~r_full;
  assign o_overrun = w_wr & r_full;

  // Capture a word when empty; drop the pending word once the arbiter is done with it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_full <= 1'b0;
      r_addr <= '0;
      r_dat  <= '0;
    end else if (w_capture) begin
      r_full <= 1'b1;
      r_addr <= i_ld_addr[23:1];
      r_dat  <= i_ld_dat;
    end else if (i_release) begin
      r_full <= 1'b0;
    end
  end

  // Back-pressure is exactly "a word is pending".
  assign o_ld_wait = r_full;
  assign o_addr    = r_addr;
  assign o_dat     = r_dat;

endmodule

// File: rtl/sdram_load_arbiter.sv
// Wishbone arbiter sharing the SDRAM port between the core and the HPS ROM
// loader. The loader wins ties in IDLE, but a core cycle is never cut short.
module sdram_load_arbiter
  import sdram_arb_pkg::*;
#(
  parameter logic [25:0] LD_BASE     = 26'h0400000,
  parameter int          ACK_TIMEOUT = 1023,
  parameter int          CNT_W       = 24
) (
  input  logic             i_clk_sys,
  input  logic             i_reset,
  input  logic             i_core_cyc,
  input  logic             i_core_stb,
  input  logic             i_core_we,
  input  logic [3:0]       i_core_sel,
  input  logic [24:0]      i_core_adr,
  input  logic [31:0]      i_core_dat_o,
  input  logic [2:0]       i_core_cti,
  output logic             o_core_ack,
  input  logic             i_ld_en,
  input  logic             i_ld_wr,
  input  logic [24:0]      i_ld_addr,
  input  logic [15:0]      i_ld_dat,
  output logic             o_ld_wait,
  output logic [CNT_W-1:0] o_ld_words,
  output logic             o_ld_err,
  output logic             o_ram_cyc,
  output logic             o_ram_stb,
  output logic             o_ram_we,
  output logic [3:0]       o_ram_sel,
  output logic [25:0]      o_ram_adr,
  output logic [31:0]      o_ram_dat,
  output logic [2:0]       o_ram_cti,
  input  logic             i_ram_ack,
  output logic             o_owner
);

  localparam logic [9:0] TO_LAST = 10'(ACK_TIMEOUT - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [9:0]       r_to_cnt;
  logic [CNT_W-1:0] r_ld_words;
  logic             r_ld_err;
  logic             r_ld_en_d;

  logic             w_ld_wait;
  logic             w_overrun;
  logic [22:0]      w_buf_addr;
  logic [15:0]      w_buf_dat;
  logic             w_ld_done;
  logic             w_timeout;
  logic             w_release;
  logic             w_ld_rise;
  logic             w_unused_core;

  // The SDRAM byte address is 26 bits, so core word-address bit 24 cannot reach it.
  assign w_unused_core = i_core_adr[24];

  assign w_ld_done = (r_state == LOAD) & i_ram_ack;
  assign w_timeout = (r_state == LOAD) & ~i_ram_ack & (r_to_cnt == TO_LAST);
  assign w_release = w_ld_done | w_timeout;
  assign w_ld_rise = i_ld_en & ~r_ld_en_d;

  ld_buffer u_ld_buffer (
    .i_clk     (i_clk_sys),
    .i_reset   (i_reset),
    .i_ld_en   (i_ld_en),
    .i_ld_wr   (i_ld_wr),
    .i_ld_addr (i_ld_addr),
    .i_ld_dat  (i_ld_dat),
    .i_release (w_release),
    .o_ld_wait (w_ld_wait),
    .o_overrun (w_overrun),
    .o_addr    (w_buf_addr),
    .o_dat     (w_buf_dat)
  );

  // Grant state register.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Grant decisions: loader first from IDLE, core keeps the bus for its whole cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_ld_wait)                     w_state_next = LOAD;
        else if (i_core_cyc && i_core_stb) w_state_next = CORE;
      end
      CORE:    if (!i_core_cyc) w_state_next = IDLE;
      LOAD:    if (w_release)   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Cycles spent waiting for the loader ack; restarts on every LOAD entry.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset)               r_to_cnt <= '0;
    else if (r_state == LOAD)  r_to_cnt <= r_to_cnt + 10'd1;
    else                       r_to_cnt <= '0;
  end

  // Loader bookkeeping: completed-write counter, sticky error, ld_en edge detect.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_ld_words <= '0;
      r_ld_err   <= 1'b0;
      r_ld_en_d  <= 1'b0;
    end else begin
      r_ld_en_d <= i_ld_en;
      if (w_ld_rise)      r_ld_words <= '0;
      else if (w_ld_done) r_ld_words <= r_ld_words + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_overrun || w_timeout) r_ld_err <= 1'b1;
      else if (w_ld_rise)         r_ld_err <= 1'b0;
    end
  end

  // SDRAM port mux: driven purely by the current grant, quiet in IDLE.
  always_comb begin
    o_ram_cyc  = 1'b0;
    o_ram_stb  = 1'b0;
    o_ram_we   = 1'b0;
    o_ram_sel  = 4'b0000;
    o_ram_adr  = '0;
    o_ram_dat  = '0;
    o_ram_cti  = CTI_CLASSIC;
    o_core_ack = 1'b0;
    case (r_state)
      CORE: begin
        o_ram_cyc  = i_core_cyc;
        o_ram_stb  = i_core_stb;
        o_ram_we   = i_core_we;
        o_ram_sel  = i_core_sel;
        o_ram_adr  = {i_core_adr[23:0], 2'b00};
        o_ram_dat  = i_core_dat_o;
        o_ram_cti  = i_core_cti;
        o_core_ack = i_ram_ack;
      end
      LOAD: begin
        o_ram_cyc = 1'b1;
        o_ram_stb = 1'b1;
        o_ram_we  = 1'b1;
        o_ram_sel = w_buf_addr[0] ? SEL_HI : SEL_LO;
        o_ram_adr = ld_to_ram_adr(LD_BASE, w_buf_addr[22:1]);
        o_ram_dat = {w_buf_dat, w_buf_dat};
        o_ram_cti = CTI_CLASSIC;
      end
      default: ;
    endcase
  end

  assign o_ld_wait  = w_ld_wait;
  assign o_ld_words = r_ld_words;
  assign o_ld_err   = r_ld_err;
  assign o_owner    = (r_state == LOAD);

endmodule

// File: tb/tb_sdram_load_arbiter.sv
// Self-checking bench for sdram_load_arbiter: vector table, directed corner
// sequences and random traffic, all compared against a cycle-level model.
module tb_sdram_load_arbiter;

  localparam logic [25:0] LD_BASE     = 26'h0400000;
  localparam int          ACK_TIMEOUT = 1023;
  localparam int          CNT_W       = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             core_cyc, core_stb, core_we;
  logic [3:0]       core_sel;
  logic [24:0]      core_adr;
  logic [31:0]      core_dat_o;
  logic [2:0]       core_cti;
  logic             core_ack;
  logic             ld_en, ld_wr;
  logic [24:0]      ld_addr;
  logic [15:0]      ld_dat;
  logic             ld_wait;
  logic [CNT_W-1:0] ld_words;
  logic             ld_err;
  logic             ram_cyc, ram_stb, ram_we;
  logic [3:0]       ram_sel;
  logic [25:0]      ram_adr;
  logic [31:0]      ram_dat;
  logic [2:0]       ram_cti;
  logic             ram_ack;
  logic             owner;

  always #5 clk = ~clk;

  sdram_load_arbiter #(.LD_BASE(LD_BASE), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk_sys(clk), .i_reset(rst),
    .i_core_cyc(core_cyc), .i_core_stb(core_stb), .i_core_we(core_we),
    .i_core_sel(core_sel), .i_core_adr(core_adr), .i_core_dat_o(core_dat_o),
    .i_core_cti(core_cti), .o_core_ack(core_ack),
    .i_ld_en(ld_en), .i_ld_wr(ld_wr), .i_ld_addr(ld_addr), .i_ld_dat(ld_dat),
    .o_ld_wait(ld_wait), .o_ld_words(ld_words), .o_ld_err(ld_err),
    .o_ram_cyc(ram_cyc), .o_ram_stb(ram_stb), .o_ram_we(ram_we),
    .o_ram_sel(ram_sel), .o_ram_adr(ram_adr), .o_ram_dat(ram_dat),
    .o_ram_cti(ram_cti), .i_ram_ack(ram_ack), .o_owner(owner)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: who holds the bus (0 nobody, 1 core, 2 loader),
  // the pending loader word and the loader bookkeeping.
  int               m_owner;
  bit               m_pend;
  logic [24:0]      m_paddr;
  logic [15:0]      m_pdat;
  int               m_ldcyc;
  logic [CNT_W-1:0] m_words;
  bit               m_err;
  bit               m_en_d;

  task automatic model_reset();
    m_owner = 0; m_pend = 0; m_paddr = '0; m_pdat = '0;
    m_ldcyc = 0; m_words = '0; m_err = 0; m_en_d = 0;
  endtask

  function automatic logic [67:0] exp_ram();
    logic [25:0] a;
    if (m_owner == 1) begin
      a = 26'(core_adr);
      a = a << 2;
      return {core_cyc, core_stb, core_we, core_sel, a, core_dat_o, core_cti};
    end else if (m_owner == 2) begin
      a = LD_BASE + 26'(m_paddr & 25'h0FFFFFC);
      return {3'b111, (m_paddr[1] ? 4'hC : 4'h3), a, m_pdat, m_pdat, 3'b000};
    end
    return '0;
  endfunction

  task automatic check_model();
    chk("ram_bus", {ram_cyc, ram_stb, ram_we, ram_sel, ram_adr, ram_dat, ram_cti}, exp_ram());
    chk("core_ack", core_ack, (m_owner == 1) ? ram_ack : 1'b0);
    chk("ld_status", {ld_wait, ld_err, owner, ld_words}, {m_pend, m_err, (m_owner == 2), m_words});
  endtask

  task automatic model_step();
    bit rise, wr, done, tout;
    int nxt;
    rise = ld_en && !m_en_d;
    wr   = ld_wr && ld_en;
    done = (m_owner == 2) && ram_ack;
    tout = (m_owner == 2) && !ram_ack && (m_ldcyc + 1 == ACK_TIMEOUT);
    nxt  = m_owner;
    if (m_owner == 0)      nxt = m_pend ? 2 : ((core_cyc && core_stb) ? 1 : 0);
    else if (m_owner == 1) nxt = core_cyc ? 1 : 0;
    else                   nxt = (done || tout) ? 0 : 2;
    if ((wr && m_pend) || tout) m_err = 1;
    else if (rise)              m_err = 0;
    if (rise)      m_words = '0;
    else if (done) m_words = m_words + 1'b1;
    m_ldcyc = (m_owner == 2 && !(done || tout)) ? m_ldcyc + 1 : 0;
    if (wr && !m_pend) begin
      m_pend = 1; m_paddr = ld_addr; m_pdat = ld_dat;
    end else if (done || tout) begin
      m_pend = 0;
    end
    m_owner = nxt;
    m_en_d  = ld_en;
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  function automatic logic [95:0] all_outs();
    return {core_ack, ld_wait, ld_words, ld_err, ram_cyc, ram_stb, ram_we,
            ram_sel, ram_adr, ram_dat, ram_cti, owner};
  endfunction

  typedef struct {
    bit          ld_wr;
    logic [24:0] ld_addr;
    logic [15:0] ld_dat;
    bit          core_on;
    bit          ram_ack;
    bit          e_owner;
    bit          e_wait;
    int          e_words;
    bit          e_cyc;
    logic [25:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
    bit          e_cack;
  } vec_t;

  vec_t vt[11];

  initial begin
    #1ms;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, n;
    bit seen;

    rst = 1'b1;
    core_cyc = 0; core_stb = 0; core_we = 1; core_sel = 4'hF;
    core_adr = 25'h10; core_dat_o = 32'hCAFEF00D; core_cti = 3'b000;
    ld_en = 0; ld_wr = 0; ld_addr = '0; ld_dat = '0; ram_ack = 0;
    model_reset();

    // Loader write followed by a simple core access, hand-derived expectations.
    vt[0]  = '{0, 25'h0, 16'h0,    0, 0, 0, 0, 0, 0, 26'h0,       4'h0, 32'h0,        0};
    vt[1]  = '{1, 25'h6, 16'hBEEF, 0, 0, 0, 0, 0, 0, 26'h0,       4'h0, 32'h0,        0};
    vt[2]  = '{0, 25'h0, 16'h0,    0, 0, 0, 1, 0, 0, 26'h0,       4'h0, 32'h0,        0};
    vt[3]  = '{0, 25'h0, 16'h0,    0, 0, 1, 1, 0, 1, 26'h0400004, 4'hC, 32'hBEEFBEEF, 0};
    vt[4]  = '{0, 25'h0, 16'h0,    0, 1, 1, 1, 0, 1, 26'h0400004, 4'hC, 32'hBEEFBEEF, 0};
    vt[5]  = '{0, 25'h0, 16'h0,    0, 0, 0, 0, 1, 0, 26'h0,       4'h0, 32'h0,        0};
    vt[6]  = '{0, 25'h0, 16'h0,    1, 0, 0, 0, 1, 0, 26'h0,       4'h0, 32'h0,        0};
    vt[7]  = '{0, 25'h0, 16'h0,    1, 0, 0, 0, 1, 1, 26'h40,      4'hF, 32'hCAFEF00D, 0};
    vt[8]  = '{0, 25'h0, 16'h0,    1, 1, 0, 0, 1, 1, 26'h40,      4'hF, 32'hCAFEF00D, 1};
    vt[9]  = '{0, 25'h0, 16'h0,    0, 0, 0, 0, 1, 0, 26'h40,      4'hF, 32'hCAFEF00D, 0};
    vt[10] = '{0, 25'h0, 16'h0,    0, 0, 0, 0, 1, 0, 26'h0,       4'h0, 32'h0,        0};

    repeat (2) begin
      @(negedge clk);
      chk("reset_state", all_outs(), '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    ld_en = 1;
    for (int i = 0; i < 11; i++) begin
      ld_wr = vt[i].ld_wr; ld_addr = vt[i].ld_addr; ld_dat = vt[i].ld_dat;
      core_cyc = vt[i].core_on; core_stb = vt[i].core_on; ram_ack = vt[i].ram_ack;
      sample();
      chk($sformatf("vec%0d", i),
          {owner, ld_wait, ld_words, ram_cyc, ram_adr, ram_sel, ram_dat, core_ack},
          {vt[i].e_owner, vt[i].e_wait, CNT_W'(vt[i].e_words), vt[i].e_cyc,
           vt[i].e_adr, vt[i].e_sel, vt[i].e_dat, vt[i].e_cack});
      advance();
    end

    // Core burst in flight when a loader word arrives: burst must finish first.
    core_cyc = 1; core_stb = 1; core_we = 0; core_cti = 3'b010; core_adr = 25'h100;
    step();
    ld_wr = 1; ld_addr = 25'h10; ld_dat = 16'h1234;
    step();
    ld_wr = 0;
    acks = 0;
    for (int b = 0; b < 4; b++) begin
      core_cti = (b == 3) ? 3'b111 : 3'b010;
      ram_ack = 1;
      sample();
      if (core_ack) acks++;
      chk("burst_owner", owner, 1'b0);
      chk("burst_wait", ld_wait, 1'b1);
      chk("burst_cti", ram_cti, core_cti);
      advance();
      core_adr = core_adr + 25'd1;
    end
    chk("burst_acks", acks, 4);
    ram_ack = 0; core_cyc = 0; core_stb = 0; core_cti = 3'b000;
    step();
    sample();
    chk("burst_idle", {owner, ld_wait}, 2'b01);
    advance();
    sample();
    chk("burst_load", {owner, ram_sel, ram_adr}, {1'b1, 4'h3, 26'h0400010});
    advance();
    ram_ack = 1; step(); ram_ack = 0;
    sample();
    chk("burst_words", {ld_words, ld_wait}, {24'd2, 1'b0});
    advance();

    // Full buffer and core request in the same IDLE cycle: loader goes first.
    ld_wr = 1; ld_addr = 25'h8; ld_dat = 16'h5A5A;
    step();
    ld_wr = 0;
    core_cyc = 1; core_stb = 1; core_we = 1; core_adr = 25'h20;
    sample();
    chk("simul_idle", owner, 1'b0);
    advance();
    ram_ack = 1;
    sample();
    chk("simul_load", {owner, core_ack, ram_sel, ram_adr, ram_dat},
        {1'b1, 1'b0, 4'h3, 26'h0400008, 32'h5A5A5A5A});
    advance();
    ram_ack = 0;
    sample();
    chk("simul_gap", {owner, core_ack}, 2'b00);
    advance();
    ram_ack = 1;
    sample();
    chk("simul_core", {core_ack, ram_adr}, {1'b1, 26'h80});
    advance();
    ram_ack = 0; core_cyc = 0; core_stb = 0;
    step(); step();

    // Overrun: a second word while the first is pending is dropped.
    ld_wr = 1; ld_addr = 25'h4; ld_dat = 16'h1111;
    step();
    ld_addr = 25'h8; ld_dat = 16'h2222;
    sample();
    chk("ovr_wait", ld_wait, 1'b1);
    advance();
    ld_wr = 0;
    sample();
    chk("ovr_load", {ld_err, owner, ram_dat, ram_adr}, {2'b11, 32'h11111111, 26'h0400004});
    advance();
    ram_ack = 1; step(); ram_ack = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("ovr_single", {owner, ld_wait, ld_words}, {2'b00, 24'd4});
      advance();
    end

    // New download clears the counters; then a write whose ack never comes.
    ld_en = 0; step();
    ld_en = 1; step();
    sample();
    chk("rise_clear", {ld_err, ld_words}, '0);
    advance();
    ld_wr = 1; ld_addr = 25'h100; ld_dat = 16'h7777; step();
    ld_wr = 0; step();
    ram_ack = 1; step(); ram_ack = 0;
    ld_wr = 1; ld_addr = 25'h200; ld_dat = 16'h8888; step();
    ld_wr = 0;
    n = 0; seen = 0;
    for (int i = 0; i < 1100; i++) begin
      sample();
      if (owner) begin
        n++;
        seen = 1;
      end else if (seen) begin
        break;
      end
      advance();
    end
    chk("timeout_cycles", n, ACK_TIMEOUT);
    chk("timeout_state", {owner, ld_wait, ld_err, ld_words}, {3'b001, 24'd1});
    advance();

    // Asynchronous reset in the middle of a loader write.
    ld_wr = 1; ld_addr = 25'h40; ld_dat = 16'h9999; step();
    ld_wr = 0; step();
    chk("pre_reset_load", {owner, ld_wait}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", all_outs(), '0);
    model_reset();
    ld_en = 0;
    @(negedge clk);
    chk("reset_hold", all_outs(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    ld_en = 1; step();
    for (int k = 0; k < 3; k++) begin
      ld_wr = 1; ld_addr = 25'(k * 4); ld_dat = 16'(k + 1); step();
      ld_wr = 0; step();
      ram_ack = 1; step(); ram_ack = 0;
    end
    sample();
    chk("post_reset", {ld_words, ld_err, ld_wait}, {24'd3, 2'b00});
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) ld_en = ~ld_en;
      if (core_cyc) begin
        if ($urandom_range(5) == 0) core_cyc = 0;
      end else if ($urandom_range(4) == 0) begin
        core_cyc = 1;
      end
      core_stb   = core_cyc & ($urandom_range(3) != 0);
      core_we    = 1'($urandom);
      core_sel   = 4'($urandom);
      core_adr   = 25'($urandom);
      core_dat_o = $urandom;
      core_cti   = 3'($urandom);
      ld_wr      = ($urandom_range(4) == 0);
      ld_addr    = 25'($urandom);
      ld_dat     = 16'($urandom);
      ram_ack    = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
